// File: rtl/bcd_feed_pkg.sv
// Shared types and constants for the binary-to-BCD display feed.
package bcd_feed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_DONE
  } state_e;

  localparam int unsigned N_BITS    = 14;
  localparam int unsigned MAX_VAL   = 9999;
  localparam logic [3:0]  ITER_LAST = 4'd13;
  localparam logic [15:0] OVF_HEXS  = 16'hEEEE;

  // Leading-zero blank mask; the units digit is never blanked.
  function automatic logic [3:0] blank_mask(input logic [15:0] h);
    return {h[15:12] == 4'd0, h[15:8] == 8'd0, h[15:4] == 12'd0, 1'b0};
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= 4'd5) d_o = d_i + 4'd3;
  end

endmodule

// File: rtl/bcd_display_feed.sv
// Sequential double-dabble converter feeding a 4-digit display driver with
// registered digits, decimal points, leading-zero blanks and overflow.
module bcd_display_feed #(
  parameter int N_BITS   = 14,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] bin,
  input  logic [3:0]        dp,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       hexs,
  output logic [3:0]        points,
  output logic [3:0]        LEs
);
  import bcd_feed_pkg::*;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [N_BITS-1:0] sh_q, sh_d;
  logic [3:0]        dp_q, dp_d;
  logic              ovf_cap_q, ovf_cap_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       hexs_q, hexs_d;
  logic [3:0]        points_q, points_d;
  logic [3:0]        les_q, les_d;

  logic [15:0]       bcd_adj;
  logic [15:0]       step_bcd;
  logic [N_BITS-1:0] step_sh;

  for (genvar g = 0; g < 4; g++) begin : g_digit
    bcd_add3 u_add3 (
      .d_i (bcd_q[4*g +: 4]),
      .d_o (bcd_adj[4*g +: 4])
    );
  end

  assign {step_bcd, step_sh} = {bcd_adj[14:0], sh_q, 1'b0};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    sh_d      = sh_q;
    dp_d      = dp_q;
    ovf_cap_d = ovf_cap_q;
    ovf_d     = ovf_q;
    hexs_d    = hexs_q;
    points_d  = points_q;
    les_d     = les_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CONV;
          sh_d      = bin;
          bcd_d     = '0;
          dp_d      = dp;
          ovf_cap_d = bin > N_BITS'(MAX_VAL);
          cnt_d     = '0;
        end
      end
      ST_CONV: begin
        bcd_d = step_bcd;
        sh_d  = step_sh;
        cnt_d = cnt_q + 4'd1;
        // Outputs are taken from the final step's result so DONE shows them at once.
        if (cnt_q == ITER_LAST) begin
          state_d = ST_DONE;
          if (ovf_cap_q) begin
            ovf_d    = 1'b1;
            hexs_d   = OVF_HEXS;
            points_d = '0;
            les_d    = '0;
          end else begin
            ovf_d    = 1'b0;
            hexs_d   = step_bcd;
            points_d = dp_q;
            les_d    = BLANK_LZ ? blank_mask(step_bcd) : 4'b0000;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bcd_q     <= '0;
      sh_q      <= '0;
      dp_q      <= '0;
      ovf_cap_q <= 1'b0;
      ovf_q     <= 1'b0;
      hexs_q    <= '0;
      points_q  <= '0;
      les_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      sh_q      <= sh_d;
      dp_q      <= dp_d;
      ovf_cap_q <= ovf_cap_d;
      ovf_q     <= ovf_d;
      hexs_q    <= hexs_d;
      points_q  <= points_d;
      les_q     <= les_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign overflow = ovf_q;
  assign hexs     = hexs_q;
  assign points   = points_q;
  assign LEs      = les_q;

endmodule
